tt_mux_ctrl: RTL and testbench

Project-select controller for the chip's project array. It keeps one project address, drives a one-hot `ena` to the project wrappers, and broadcasts the packed 18-bit input word `{uio_in, ui_in, rst_n, clk}` to every wrapper. It returns the 24-bit output word `{uio_oe, uio_out, uo_out}` of the selected wrapper only. Each selection change passes through a guard window in which no project is enabled and the broadcast word is zero.

---
 rtl/tt_mux_pkg.sv | 21 ++
 rtl/tt_mux_outsel.sv | 23 ++
 rtl/tt_mux_ctrl.sv | 144 ++++++++++++++
 tb/tb_tt_mux_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_mux_pkg.sv
// Shared types and constants for the project-select mux controller.
package tt_mux_pkg;

  localparam int IW_W = 18;
  localparam int OW_W = 24;

  // Bit positions inside the broadcast input word {uio_in, ui_in, rst_n, clk}
  localparam int IW_CLK    = 0;
  localparam int IW_RST_N  = 1;
  localparam int IW_UI_LO  = 2;
  localparam int IW_UI_HI  = 9;
  localparam int IW_UIO_LO = 10;
  localparam int IW_UIO_HI = 17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    ACTIVE = 2'd2
  } mux_state_t;

endpackage

// File: rtl/tt_mux_outsel.sv
// N_PROJ-to-1 selector of project output words, forced to zero when disabled.
module tt_mux_outsel
  import tt_mux_pkg::*;
#(
  parameter int N_PROJ = 4,
  parameter int ADDR_W = $clog2(N_PROJ)
) (
  input  logic [OW_W*N_PROJ-1:0] ow_in_i,
  input  logic [ADDR_W-1:0]      sel_i,
  input  logic                   en_i,
  output logic [OW_W-1:0]        ow_o
);

  always_comb begin
    ow_o = '0;
    for (int k = 0; k < N_PROJ; k++) begin
      if (en_i && (sel_i == ADDR_W'(k))) begin
        ow_o = ow_in_i[k*OW_W +: OW_W];
      end
    end
  end

endmodule

// File: rtl/tt_mux_ctrl.sv
// Project-select controller: address counter, guarded switch FSM, one-hot enable
// decode and the gated input/output word paths to the project wrappers.
module tt_mux_ctrl
  import tt_mux_pkg::*;
#(
  parameter int N_PROJ = 4,
  parameter int ADDR_W = $clog2(N_PROJ),
  parameter int GUARD  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sel_rst,
  input  logic                   sel_inc,
  input  logic                   ctrl_ena,
  input  logic [IW_W-1:0]        iw_in,
  output logic [IW_W-1:0]        iw_out,
  input  logic [OW_W*N_PROJ-1:0] ow_in,
  output logic [OW_W-1:0]        ow_out,
  output logic [N_PROJ-1:0]      ena,
  output logic [ADDR_W-1:0]      cur_addr,
  output logic                   busy
);

  localparam int                CNT_W     = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [CNT_W-1:0]  GUARD_LD  = CNT_W'(GUARD - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PROJ - 1);

  logic               sel_rst_q, sel_inc_q, sel_inc_prev_q;
  logic               ctrl_ena_q, ctrl_ena_prev_q;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               chg_q, chg_d;
  logic               inc_pulse;
  mux_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_PROJ-1:0]  ena_q, ena_d;
  logic               busy_q, busy_d;
  logic [N_PROJ-1:0]  addr_onehot;

  assign inc_pulse = sel_inc_q & ~sel_inc_prev_q;

  always_comb begin
    addr_d = addr_q;
    if (sel_rst_q) begin
      addr_d = '0;
    end else if (inc_pulse) begin
      addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
    end
  end

  // Change is registered so the FSM reacts one cycle after the address/enable update.
  assign chg_d = (addr_d != addr_q) | (ctrl_ena_q ^ ctrl_ena_prev_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_rst_q       <= 1'b0;
      sel_inc_q       <= 1'b0;
      sel_inc_prev_q  <= 1'b0;
      ctrl_ena_q      <= 1'b0;
      ctrl_ena_prev_q <= 1'b0;
      addr_q          <= '0;
      chg_q           <= 1'b0;
    end else begin
      sel_rst_q       <= sel_rst;
      sel_inc_q       <= sel_inc;
      sel_inc_prev_q  <= sel_inc_q;
      ctrl_ena_q      <= ctrl_ena;
      ctrl_ena_prev_q <= ctrl_ena_q;
      addr_q          <= addr_d;
      chg_q           <= chg_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ena_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ena_q   <= ena_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (chg_q) begin
          state_d = DRAIN;
          cnt_d   = GUARD_LD;
        end
      end
      DRAIN: begin
        if (chg_q) begin
          cnt_d = GUARD_LD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!chg_d) begin
          // Holding off while an address update is in flight keeps ena and the muxes aligned.
          state_d = ctrl_ena_q ? ACTIVE : IDLE;
        end
      end
      ACTIVE: begin
        if (chg_q) begin
          state_d = DRAIN;
          cnt_d   = GUARD_LD;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  for (genvar gi = 0; gi < N_PROJ; gi++) begin : g_dec
    assign addr_onehot[gi] = (addr_q == ADDR_W'(gi));
  end

  always_comb begin
    ena_d  = (state_d == ACTIVE) ? addr_onehot : '0;
    busy_d = (state_d == DRAIN);
  end

  assign ena      = ena_q;
  assign busy     = busy_q;
  assign cur_addr = addr_q;
  assign iw_out   = (state_q == ACTIVE) ? iw_in : '0;

  tt_mux_outsel #(
    .N_PROJ (N_PROJ),
    .ADDR_W (ADDR_W)
  ) u_outsel (
    .ow_in_i (ow_in),
    .sel_i   (addr_q),
    .en_i    (state_q == ACTIVE),
    .ow_o    (ow_out)
  );

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// Scoreboard bench for tt_mux_ctrl with N_PROJ=4, GUARD=2.
module tb_tt_mux_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel_rst, sel_inc, ctrl_ena;
  logic [17:0] iw_in, iw_out;
  logic [95:0] ow_in;
  logic [23:0] ow_out;
  logic [3:0]  ena;
  logic [1:0]  cur_addr;
  logic        busy;

  tt_mux_ctrl #(.N_PROJ(4), .GUARD(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel_rst  (sel_rst),
    .sel_inc  (sel_inc),
    .ctrl_ena (ctrl_ena),
    .iw_in    (iw_in),
    .iw_out   (iw_out),
    .ow_in    (ow_in),
    .ow_out   (ow_out),
    .ena      (ena),
    .cur_addr (cur_addr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [3:0]  ena;
    logic [1:0]  addr;
    logic        busy;
    bit          data;
    logic [17:0] iw;
    logic [23:0] ow;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [23:0] slice(input int k);
    return ow_in[24*k +: 24];
  endfunction

  function automatic logic [3:0] onehot(input int a);
    logic [3:0] v;
    v = 4'b0001;
    return v << a;
  endfunction

  task automatic push(input int c, input string tag, input logic [3:0] e, input logic [1:0] a,
                      input logic b, input bit d, input logic [17:0] iw, input logic [23:0] ow);
    exp_t x;
    x.cyc = c; x.ena = e; x.addr = a; x.busy = b; x.data = d; x.iw = iw; x.ow = ow;
    sb.push_back(x);
    sb_tag.push_back(tag);
  endtask

  // Expected trace of one guarded switch whose input was sampled at edge k.
  task automatic expect_switch(input int k, input string tag, input logic [3:0] old_ena,
                               input logic [3:0] new_ena, input logic [1:0] a,
                               input logic [17:0] iw_e, input logic [23:0] ow_e);
    push(k + 1, {tag, "_k1"},     old_ena, a, 1'b0, 1'b0, '0, '0);
    push(k + 2, {tag, "_drain0"}, 4'b0,    a, 1'b1, 1'b1, '0, '0);
    push(k + 3, {tag, "_drain1"}, 4'b0,    a, 1'b1, 1'b1, '0, '0);
    push(k + 4, {tag, "_done"},   new_ena, a, 1'b0, 1'b1, iw_e, ow_e);
  endtask

  always @(negedge clk) begin
    check("onehot", $onehot0(ena) ? 32'd1 : 32'd0, 32'd1);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t  e;
      string t;
      e = sb.pop_front();
      t = sb_tag.pop_front();
      if (e.cyc < cyc) begin
        check({t, "_missed"}, cyc, e.cyc);
      end else begin
        $display("txn %s cyc %0d ena %b addr %0d busy %b iw %h ow %h",
                 t, cyc, ena, cur_addr, busy, iw_out, ow_out);
        check({t, "_ena"},  ena,      e.ena);
        check({t, "_addr"}, cur_addr, e.addr);
        check({t, "_busy"}, busy,     e.busy);
        if (e.data) begin
          check({t, "_iw"}, iw_out, e.iw);
          check({t, "_ow"}, ow_out, e.ow);
        end
      end
    end
  end

  task automatic wait_sb(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk); #1;
    end
    check("sb_timeout", sb.size(), 0);
    sb.delete();
    sb_tag.delete();
  endtask

  task automatic next_slot(output int k);
    @(negedge clk); #1;
    k = cyc + 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; sel_rst = 1'b0; sel_inc = 1'b0; ctrl_ena = 1'b0;
    iw_in = 18'h2ABCD;
    ow_in = {24'h0C0C03, 24'h0B0B02, 24'h0A0A01, 24'h123456};
    repeat (2) @(negedge clk);
    check("rst_ena",  ena,      4'b0);
    check("rst_addr", cur_addr, 2'd0);
    check("rst_busy", busy,     1'b0);
    check("rst_iw",   iw_out,   18'h0);
    check("rst_ow",   ow_out,   24'h0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) push(cyc + i, "idle", 4'b0, 2'd0, 1'b0, 1'b1, '0, '0);
    wait_sb(10);

    // Enable project 0
    next_slot(k);
    ctrl_ena = 1'b1;
    expect_switch(k, "en0", 4'b0, 4'b0001, 2'd0, 18'h2ABCD, 24'h123456);
    wait_sb(20);

    // Three increments while active
    for (int a = 1; a <= 3; a++) begin
      repeat (4) @(negedge clk);
      next_slot(k);
      iw_in = 18'($urandom);
      sel_inc = 1'b1;
      expect_switch(k, "inc", onehot(a - 1), onehot(a), 2'(a), iw_in, slice(a));
      @(negedge clk); #1;
      sel_inc = 1'b0;
      wait_sb(20);
    end

    // Wrap
    next_slot(k);
    sel_inc = 1'b1;
    expect_switch(k, "wrap", 4'b1000, 4'b0001, 2'd0, iw_in, slice(0));
    @(negedge clk); #1;
    sel_inc = 1'b0;
    wait_sb(20);

    // Rapid edges one cycle apart: a single extended drain ending on address 2
    next_slot(k);
    sel_inc = 1'b1;
    push(k + 1, "rapid_k1", 4'b0001, 2'd1, 1'b0, 1'b0, '0, '0);
    push(k + 2, "rapid_d0", 4'b0,    2'd1, 1'b1, 1'b1, '0, '0);
    push(k + 3, "rapid_d1", 4'b0,    2'd2, 1'b1, 1'b1, '0, '0);
    push(k + 4, "rapid_d2", 4'b0,    2'd2, 1'b1, 1'b1, '0, '0);
    push(k + 5, "rapid_d3", 4'b0,    2'd2, 1'b1, 1'b1, '0, '0);
    push(k + 6, "rapid_on", 4'b0100, 2'd2, 1'b0, 1'b1, iw_in, slice(2));
    @(negedge clk); #1; sel_inc = 1'b0;
    @(negedge clk); #1; sel_inc = 1'b1;
    @(negedge clk); #1; sel_inc = 1'b0;
    wait_sb(20);

    // sel_rst wins over a simultaneous increment edge
    repeat (3) @(negedge clk);
    next_slot(k);
    sel_rst = 1'b1;
    sel_inc = 1'b1;
    expect_switch(k, "prio", 4'b0100, 4'b0001, 2'd0, iw_in, slice(0));
    @(negedge clk); #1;
    sel_rst = 1'b0;
    sel_inc = 1'b0;
    wait_sb(20);

    // sel_inc held high: exactly one increment
    next_slot(k);
    sel_inc = 1'b1;
    expect_switch(k, "hold", 4'b0001, 4'b0010, 2'd1, iw_in, slice(1));
    push(k + 20, "hold_k20", 4'b0010, 2'd1, 1'b0, 1'b1, iw_in, slice(1));
    wait_sb(30);
    next_slot(k);
    sel_inc = 1'b0;
    push(k + 5, "hold_rel", 4'b0010, 2'd1, 1'b0, 1'b1, iw_in, slice(1));
    wait_sb(20);

    // Disable: drain then idle with outputs gated off
    next_slot(k);
    ctrl_ena = 1'b0;
    expect_switch(k, "dis", 4'b0010, 4'b0, 2'd1, '0, '0);
    push(k + 8, "dis_idle", 4'b0, 2'd1, 1'b0, 1'b1, '0, '0);
    wait_sb(20);

    // Re-enable, then reset asynchronously mid-ACTIVE
    next_slot(k);
    ctrl_ena = 1'b1;
    expect_switch(k, "reen", 4'b0, 4'b0010, 2'd1, iw_in, slice(1));
    wait_sb(20);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_ena",  ena,      4'b0);
    check("arst_addr", cur_addr, 2'd0);
    check("arst_busy", busy,     1'b0);
    check("arst_iw",   iw_out,   18'h0);
    check("arst_ow",   ow_out,   24'h0);
    ctrl_ena = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) push(cyc + i, "post_rst", 4'b0, 2'd0, 1'b0, 1'b1, '0, '0);
    wait_sb(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
